// File: rtl/spi_led_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_led_responder
//
// SPI mode-0 slave that terminates the robot-side end of the LED-control link.
// It oversamples SCLK / MOSI / SSBar on the system clock, assembles bytes
// MSB-first and parses the 6-byte SET_LED frame:
//   byte 0 address, byte 1 message type, byte 2 LED id, bytes 3..5 R/G/B.
// A complete, correctly addressed SET_LED frame updates the four registered
// outputs and pulses led_valid for one cycle. A frame that was addressed to us
// but aborted (SSBar released early) pulses frame_err for one cycle and leaves
// the outputs untouched.
//
// Optional build macro:
//   SPI_RESP_MISO_EN  - echo mode. During byte n, MISO returns byte n-1 as it
//                       was received (8'h00 during byte 0). Without the macro
//                       MISO is tied to 0 and no transmit logic exists.
//
// Parameters:
//   ADDR        slave address expected in byte 0
//   MSG_SET_LED message code accepted in byte 1
//   SYNC_STAGES synchronizer depth on SCLK/MOSI/SSBar (>= 2)
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   SCLK       SPI clock from master (mode 0, idle low)
//   MOSI       serial data from master, MSB first
//   SSBar      slave select, active low
//   MISO       serial data to master
//   led_id     LED id from last valid frame
//   red        red value from last valid frame
//   green      green value from last valid frame
//   blue       blue value from last valid frame
//   led_valid  one-cycle strobe when the four outputs above update
//   frame_err  one-cycle strobe on an aborted, addressed frame
// -----------------------------------------------------------------------------
module spi_led_responder #(
  parameter logic [7:0] ADDR        = 8'h08,
  parameter logic [7:0] MSG_SET_LED = 8'h06,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       SSBar,
  output logic       MISO,
  output logic [7:0] led_id,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       led_valid,
  output logic       frame_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_MSG,
    S_LED,
    S_RED,
    S_GREEN,
    S_BLUE,
    S_DONE,
    S_SKIP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic [SYNC_STAGES-1:0] r_ssSync;
  logic                   r_sclkPrev;
  logic                   r_ssPrev;

  logic w_sclk;
  logic w_mosi;
  logic w_ss;
  logic w_sclkRise;
  logic w_ssRise;
  logic w_ssFall;

  // The SSBar chain and its edge-detect history reset to the deselected level
  // so that leaving reset with the slave deselected never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclkSync <= '0;
      r_mosiSync <= '0;
      r_ssSync   <= '1;
      r_sclkPrev <= 1'b0;
      r_ssPrev   <= 1'b1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], SCLK};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], MOSI};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], SSBar};
      r_sclkPrev <= w_sclk;
      r_ssPrev   <= w_ss;
    end
  end

  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_ss       = r_ssSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_ssRise   = w_ss & ~r_ssPrev;
  assign w_ssFall   = ~w_ss & r_ssPrev;

  // ---------------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------------
  logic [7:0] r_rxShift;
  logic [2:0] r_bitCnt;
  logic [7:0] r_rxByte;
  logic       r_byteDone;
  logic       r_ssRiseQ;
  logic       r_ssFallQ;
  logic [7:0] w_rxNext;

  assign w_rxNext = {r_rxShift[6:0], w_mosi};

  // The bit counter is held at zero for as long as the slave is deselected,
  // which both clears it for the next frame and throws away a partial byte
  // when SSBar is released mid-byte. The SSBar edges are delayed by one
  // register so the FSM sees them aligned with byte_done, giving both strobes
  // the same latency from the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxShift  <= 8'h00;
      r_bitCnt   <= 3'd0;
      r_rxByte   <= 8'h00;
      r_byteDone <= 1'b0;
      r_ssRiseQ  <= 1'b0;
      r_ssFallQ  <= 1'b0;
    end else begin
      r_byteDone <= 1'b0;
      r_ssRiseQ  <= w_ssRise;
      r_ssFallQ  <= w_ssFall;
      if (w_ss) begin
        r_rxShift <= 8'h00;
        r_bitCnt  <= 3'd0;
      end else if (w_sclkRise) begin
        r_rxShift <= w_rxNext;
        r_bitCnt  <= r_bitCnt + 3'd1;
        if (r_bitCnt == 3'd7) begin
          r_byteDone <= 1'b1;
          r_rxByte   <= w_rxNext;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [7:0] r_stageLed;
  logic [7:0] r_stageRed;
  logic [7:0] r_stageGreen;
  logic [7:0] r_ledId;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_ledValid;
  logic       r_frameErr;

  // Releasing SSBar takes priority over a byte completing in the same cycle,
  // so a frame whose last byte lands together with deselect counts as
  // aborted. Only the payload states report an abort; a frame that was never
  // addressed to us, or carried another message type, ends silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_stageLed   <= 8'h00;
      r_stageRed   <= 8'h00;
      r_stageGreen <= 8'h00;
      r_ledId      <= 8'h00;
      r_red        <= 8'h00;
      r_green      <= 8'h00;
      r_blue       <= 8'h00;
      r_ledValid   <= 1'b0;
      r_frameErr   <= 1'b0;
    end else begin
      r_ledValid <= 1'b0;
      r_frameErr <= 1'b0;
      if (r_ssRiseQ) begin
        if (r_state inside {S_MSG, S_LED, S_RED, S_GREEN, S_BLUE}) begin
          r_frameErr <= 1'b1;
        end
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_ssFallQ) begin
              r_state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (r_byteDone) begin
              r_state <= (r_rxByte == ADDR) ? S_MSG : S_SKIP;
            end
          end
          S_MSG: begin
            if (r_byteDone) begin
              r_state <= (r_rxByte == MSG_SET_LED) ? S_LED : S_SKIP;
            end
          end
          S_LED: begin
            if (r_byteDone) begin
              r_stageLed <= r_rxByte;
              r_state    <= S_RED;
            end
          end
          S_RED: begin
            if (r_byteDone) begin
              r_stageRed <= r_rxByte;
              r_state    <= S_GREEN;
            end
          end
          S_GREEN: begin
            if (r_byteDone) begin
              r_stageGreen <= r_rxByte;
              r_state      <= S_BLUE;
            end
          end
          S_BLUE: begin
            if (r_byteDone) begin
              r_ledId    <= r_stageLed;
              r_red      <= r_stageRed;
              r_green    <= r_stageGreen;
              r_blue     <= r_rxByte;
              r_ledValid <= 1'b1;
              r_state    <= S_DONE;
            end
          end
          S_DONE, S_SKIP: begin
            r_state <= r_state;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign led_id    = r_ledId;
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign led_valid = r_ledValid;
  assign frame_err = r_frameErr;

  // ---------------------------------------------------------------------------
  // MISO
  // ---------------------------------------------------------------------------
`ifdef SPI_RESP_MISO_EN
  localparam logic [7:0] ECHO_FIRST = 8'h00;

  logic [7:0] r_txShift;
  logic       r_miso;
  logic       w_sclkFall;

  assign w_sclkFall = r_sclkPrev & ~w_sclk;

  // r_txShift always holds the bits still to be presented, MSB next. On
  // select, the first byte's MSB goes straight onto MISO so the master can
  // sample it on the first rising edge. At each completed byte the whole
  // received byte is reloaded; the falling edge that follows puts its MSB
  // out, which keeps every byte aligned with the master's sampling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txShift <= 8'h00;
      r_miso    <= 1'b0;
    end else if (w_ssFall) begin
      r_txShift <= {ECHO_FIRST[6:0], 1'b0};
      r_miso    <= ECHO_FIRST[7];
    end else if (!w_ss) begin
      if (w_sclkRise && (r_bitCnt == 3'd7)) begin
        r_txShift <= w_rxNext;
      end else if (w_sclkFall) begin
        r_miso    <= r_txShift[7];
        r_txShift <= {r_txShift[6:0], 1'b0};
      end
    end
  end

  assign MISO = r_miso;
`else
  assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_led_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_led_responder
//
// Drives SET_LED frames (directed cases plus randomized frames) into the
// responder as an SPI mode-0 master. Each frame's expected outcome is decided
// from the frame rules and pushed into a scoreboard queue together with the
// clock cycle on which the strobe must appear; a separate monitor pops and
// compares whenever led_valid or frame_err is seen.
// -----------------------------------------------------------------------------
module tb_spi_led_responder;

  localparam int         SYNC = 2;
  localparam logic [7:0] ADDR = 8'h08;
  localparam logic [7:0] MSG  = 8'h06;
  localparam int         HALF = 6;

  localparam int KIND_LED = 1;
  localparam int KIND_ERR = 2;

  typedef logic [7:0] byteQ_t[$];

  typedef struct {
    int         kind;
    logic [7:0] id;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       SCLK  = 1'b0;
  logic       MOSI  = 1'b0;
  logic       SSBar = 1'b1;
  logic       MISO;
  logic [7:0] led_id;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       led_valid;
  logic       frame_err;

  int   nTests   = 0;
  int   nFails   = 0;
  int   cycleCnt = 0;
  exp_t expQ[$];
  exp_t monItem;

  // Model of the output registers as they should stand after each frame.
  logic [7:0] mdlId = 8'h00;
  logic [7:0] mdlR  = 8'h00;
  logic [7:0] mdlG  = 8'h00;
  logic [7:0] mdlB  = 8'h00;

  spi_led_responder #(
    .ADDR        (ADDR),
    .MSG_SET_LED (MSG),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .SSBar     (SSBar),
    .MISO      (MISO),
    .led_id    (led_id),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .led_valid (led_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    nTests++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  // Builds a byte queue from the top nBytes bytes of v.
  function automatic byteQ_t mkFrame(input logic [63:0] v, input int nBytes);
    byteQ_t q;
    for (int k = 0; k < nBytes; k++) q.push_back(v[63-8*k -: 8]);
    return q;
  endfunction

  // Frame rules: what happens once nBits bits of the frame have been clocked
  // in and the master releases select. 0 = silent, 1 = LED update, 2 = error.
  function automatic int refOutcome(input byteQ_t b, input int nBits);
    int nBytes;
    nBytes = nBits / 8;
    if (nBytes == 0) return 0;
    if (b[0] != ADDR) return 0;
    if (nBytes == 1) return KIND_ERR;
    if (b[1] != MSG) return 0;
    if (nBytes >= 6) return KIND_LED;
    return KIND_ERR;
  endfunction

  // Scoreboard monitor: every strobe must match the head of the queue in
  // kind, cycle and (for led_valid) value.
  always @(negedge clk) begin
    if (!rst && (led_valid || frame_err)) begin
      compare("strobe_exclusive", {31'd0, led_valid & frame_err}, 32'd0);
      if (expQ.size() == 0) begin
        nTests++;
        nFails++;
        $display("[TB] FAIL unexpected_strobe: got led_valid=%0b frame_err=%0b, expected no strobe (cycle %0d)",
                 led_valid, frame_err, cycleCnt);
      end else begin
        monItem = expQ.pop_front();
        compare("strobe_kind", {30'd0, frame_err, led_valid},
                (monItem.kind == KIND_LED) ? 32'd1 : 32'd2);
        compare("strobe_cycle", cycleCnt, monItem.cyc);
        if (monItem.kind == KIND_LED) begin
          compare("strobe_led_id", {24'd0, led_id}, {24'd0, monItem.id});
          compare("strobe_red",    {24'd0, red},    {24'd0, monItem.r});
          compare("strobe_green",  {24'd0, green},  {24'd0, monItem.g});
          compare("strobe_blue",   {24'd0, blue},   {24'd0, monItem.b});
        end
      end
    end
  end

  // Held outputs must equal the model and no expected strobe may be missing.
  task automatic checkOutput(input string tag);
    compare({tag, "_led_id"}, {24'd0, led_id}, {24'd0, mdlId});
    compare({tag, "_red"},    {24'd0, red},    {24'd0, mdlR});
    compare({tag, "_green"},  {24'd0, green},  {24'd0, mdlG});
    compare({tag, "_blue"},   {24'd0, blue},   {24'd0, mdlB});
    compare({tag, "_pending_strobes"}, expQ.size(), 32'd0);
    expQ.delete();
  endtask

  // Clocks nBits bits of the byte queue out as an SPI master, releases
  // select, and registers the expected strobes. If resetAtBit >= 0, reset is
  // asserted just before that bit's rising edge and the frame is abandoned.
  task automatic applyStimulus(input string tag, input byteQ_t bytes, input int nBits,
                               input int resetAtBit);
    int         outcome;
    logic [7:0] misoByte;
    logic [7:0] misoExp;
    exp_t       e;
    outcome  = refOutcome(bytes, nBits);
    misoByte = 8'h00;
    @(negedge clk);
    SSBar = 1'b0;
    MOSI  = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      if ((i % 8 == 0) && (i > 0)) repeat ($urandom_range(0, 8)) @(negedge clk);
      MOSI = bytes[i/8][7 - (i % 8)];
      repeat (HALF) @(negedge clk);
      if (i == resetAtBit) begin
        rst = 1'b1;
        #1;
        compare("reset_mid_led_id",    {24'd0, led_id}, 32'd0);
        compare("reset_mid_red",       {24'd0, red},    32'd0);
        compare("reset_mid_green",     {24'd0, green},  32'd0);
        compare("reset_mid_blue",      {24'd0, blue},   32'd0);
        compare("reset_mid_strobes",   {30'd0, led_valid, frame_err}, 32'd0);
        mdlId = 8'h00; mdlR = 8'h00; mdlG = 8'h00; mdlB = 8'h00;
        SCLK  = 1'b0;
        SSBar = 1'b1;
        MOSI  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput({tag, "_after_reset"});
        return;
      end
      misoByte[7 - (i % 8)] = MISO;
      SCLK = 1'b1;
      if ((i == 47) && (outcome == KIND_LED)) begin
        e.kind = KIND_LED;
        e.id   = bytes[2];
        e.r    = bytes[3];
        e.g    = bytes[4];
        e.b    = bytes[5];
        e.cyc  = cycleCnt + SYNC + 2;
        expQ.push_back(e);
        mdlId = bytes[2]; mdlR = bytes[3]; mdlG = bytes[4]; mdlB = bytes[5];
      end
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
      if (i % 8 == 7) begin
`ifdef SPI_RESP_MISO_EN
        misoExp = (i < 8) ? 8'h00 : bytes[i/8 - 1];
`else
        misoExp = 8'h00;
`endif
        compare({tag, "_miso_byte"}, {24'd0, misoByte}, {24'd0, misoExp});
      end
    end
    repeat (HALF) @(negedge clk);
    SSBar = 1'b1;
    if (outcome == KIND_ERR) begin
      e.kind = KIND_ERR;
      e.id = 8'h00; e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
      e.cyc  = cycleCnt + SYNC + 2;
      expQ.push_back(e);
    end
    repeat (12) @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    #900us;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byteQ_t f;
    int     nB;
    int     nBits;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compare("reset_miso",      {31'd0, MISO},      32'd0);
    compare("reset_led_id",    {24'd0, led_id},    32'd0);
    compare("reset_red",       {24'd0, red},       32'd0);
    compare("reset_green",     {24'd0, green},     32'd0);
    compare("reset_blue",      {24'd0, blue},      32'd0);
    compare("reset_led_valid", {31'd0, led_valid}, 32'd0);
    compare("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] directed frames");
    applyStimulus("wrong_addr", mkFrame(64'h0906_02FF_FFFF_0000, 6), 48, -1);
    applyStimulus("nominal",    mkFrame(64'h0806_0201_0101_0000, 6), 48, -1);
    applyStimulus("abort_4b",   mkFrame(64'h0806_027F_0000_0000, 4), 32, -1);
    applyStimulus("abort_35",   mkFrame(64'h0806_027F_A500_0000, 5), 35, -1);
    applyStimulus("unknown_msg", mkFrame(64'h0805_0211_2233_0000, 6), 48, -1);
    applyStimulus("rgb_102030", mkFrame(64'h0806_0310_2030_0000, 6), 48, -1);
    applyStimulus("reset_mid",  mkFrame(64'h0806_0455_6677_0000, 6), 48, 27);
    applyStimulus("post_reset", mkFrame(64'h0806_05AA_BBCC_0000, 6), 48, -1);

    $display("[TB] random frames");
    for (int t = 0; t < 30; t++) begin
      f.delete();
      nB = $urandom_range(0, 7);
      for (int k = 0; k <= nB; k++) begin
        if (k == 0)      f.push_back(($urandom_range(0, 3) != 0) ? ADDR : 8'($urandom));
        else if (k == 1) f.push_back(($urandom_range(0, 3) != 0) ? MSG  : 8'($urandom));
        else             f.push_back(8'($urandom));
      end
      nBits = nB * 8 + (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0);
      applyStimulus("random", f, nBits, -1);
    end

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule

// File: doc/spi_led_responder.md
# spi_led_responder

SPI slave that terminates the LED-control link on the robot side. It receives the 6-byte SET_LED frame sent by the host-side LED controller: address, message type, LED id, red, green, blue. The host runs at 12 MHz and drives SCK at 1 MHz. The block oversamples SCLK, MOSI and SSBar on the system clock, assembles and parses the bytes, and publishes the decoded LED command as registered outputs with a one-cycle strobe.

## Interface
Parameters:
- ADDR, 8'h08, slave address expected in byte 0
- MSG_SET_LED, 8'h06, message code accepted in byte 1
- SYNC_STAGES, 2, synchronizer depth on SCLK/MOSI/SSBar (≥2)

Ports:
- clk  in  1  system clock (12 MHz)
- rst  in  1  asynchronous, active-high reset
- SCLK  in  1  SPI clock from master, mode 0, idle low
- MOSI  in  1  serial data from master, MSB first
- SSBar  in  1  slave select, active low
- MISO  out  1  serial data to master
- led_id  out  8  LED id from last valid frame
- red  out  8  red value from last valid frame
- green  out  8  green value from last valid frame
- blue  out  8  blue value from last valid frame
- led_valid  out  1  one-cycle strobe when the four outputs above update
- frame_err  out  1  one-cycle strobe on an aborted, addressed frame

## Operation
- SCLK, MOSI and SSBar each pass through a SYNC_STAGES flop chain. During reset, the SSBar chain initialises to 1.
- Edge detect on synchronized SCLK:
  - rising edge: shift MOSI into rx_shift[7:0] MSB-first; increment bit_cnt[2:0].
  - falling edge: shift tx_shift out on MISO.
- A byte completes when bit_cnt wraps 7→0 on a rising edge. rx_byte is then valid for one cycle (byte_done).
- FSM states: IDLE, ADDR, MSG, LED, RED, GREEN, BLUE, DONE, SKIP.
  - IDLE: on synchronized SSBar falling, clear bit_cnt and go to ADDR.
  - ADDR: on byte_done, go to MSG if rx_byte==ADDR, else SKIP (silent).
  - MSG: on byte_done, go to LED if rx_byte==MSG_SET_LED, else SKIP (silent; other message types are not errors).
  - LED / RED / GREEN: on byte_done, capture the byte into a staging register and advance.
  - BLUE: on byte_done, copy the staging registers and the blue byte into the outputs, pulse led_valid, and go to DONE.
  - DONE, SKIP: ignore all further bytes.
- Any state: synchronized SSBar rising returns the FSM to IDLE and discards any partial byte.
  - If the state was MSG, LED, RED, GREEN or BLUE, pulse frame_err. The outputs keep their previous values.
- Outputs change only on a complete valid frame. A partial frame never alters them.
- Reset mid-frame: immediate return to IDLE, all outputs cleared, staging discarded.

## Timing
- Reset values: MISO=0, led_id=red=green=blue=8'h00, led_valid=0, frame_err=0, state IDLE.
- Edge latency: a pin-level SCLK edge is acted on SYNC_STAGES+1 clk cycles later.
- led_valid asserts SYNC_STAGES+2 clk cycles after the 8th rising SCLK edge of byte 5. The new output values are visible in the same cycle as the strobe.
- frame_err asserts SYNC_STAGES+2 clk cycles after the pin-level SSBar rises.
- led_valid and frame_err are never high together, and neither lasts more than one cycle.
- Input constraint: the SCLK high time and low time must each be ≥ SYNC_STAGES+1 clk periods. At 12 MHz with 1 MHz SCK each phase is 6 clk.
- Gaps of any length between bytes are allowed while SSBar stays low.

## Configuration
- SPI_RESP_MISO_EN defined (echo mode):
  - During byte n, MISO shifts out byte n-1 as received.
  - During byte 0, MISO shifts out 8'h00.
  - On SSBar falling, tx_shift loads and its MSB is driven onto MISO.
  - After each byte_done, tx_shift reloads from rx_byte.
- SPI_RESP_MISO_EN undefined: MISO is constant 0. The tx_shift logic is absent.
- Frame decoding is identical in both builds.

## Test plan
- Nominal frame 08 06 02 01 01 01 at 1 MHz SCK, then SSBar high → one led_valid pulse with led_id=02, red=01, green=01, blue=01; frame_err stays 0.
- Wrong address: frame 09 06 02 FF FF FF → no led_valid, no frame_err, outputs remain 00.
- Abort: 08 06 02 7F, then SSBar high after 4 bytes → one frame_err pulse; outputs unchanged from the previous frame. Repeat with SSBar rising after 3 bits of byte 4 → same result.
- Unknown message 08 05 … (6 bytes) → silent, no strobes. A following nominal frame with RGB 10/20/30 → led_valid with those values.
- Reset asserted mid-byte during a nominal frame → all outputs 00 asynchronously. The next full frame decodes correctly.
- With SPI_RESP_MISO_EN defined, nominal frame → MISO bytes sampled on SCLK rising edges read 00 08 06 02 01 01. Undefined → MISO stays 0 throughout.
